// File: rtl/melody_pkg.sv
// melody_pkg: shared note constants, melody IDs, ROM entry layout and sequencer states
package melody_pkg;
    localparam int FREQ_W  = 10;
    localparam int DUR_W   = 6;
    localparam int ENTRY_W = FREQ_W + DUR_W;

    localparam logic [FREQ_W-1:0] NOTE_C4  = 10'd262;
    localparam logic [FREQ_W-1:0] NOTE_DS4 = 10'd311;
    localparam logic [FREQ_W-1:0] NOTE_E4  = 10'd330;
    localparam logic [FREQ_W-1:0] NOTE_G4  = 10'd392;
    localparam logic [FREQ_W-1:0] NOTE_C5  = 10'd523;
    localparam logic [FREQ_W-1:0] NOTE_E5  = 10'd659;
    localparam logic [FREQ_W-1:0] NOTE_G5  = 10'd784;
    localparam logic [FREQ_W-1:0] NOTE_B5  = 10'd988;

    localparam logic [1:0] MEL_START    = 2'd0;
    localparam logic [1:0] MEL_GAMEOVER = 2'd1;
    localparam logic [1:0] MEL_LEVELUP  = 2'd2;
    localparam logic [1:0] MEL_SILENT   = 2'd3;

    typedef enum logic [2:0] {IDLE, FETCH, NOTE, GAP, DONE} state_t;

    function automatic logic [ENTRY_W-1:0] mk_entry(input logic [FREQ_W-1:0] f, input logic [DUR_W-1:0] d);
        return {f, d};
    endfunction
endpackage

// File: rtl/melody_rom.sv
// melody_rom: combinational jingle table, (melody, index) -> {freq, dur}; unlisted slots read as end marker
module melody_rom
    import melody_pkg::*;
#(
    parameter int MAX_NOTES = 16,
    localparam int IDX_W = $clog2(MAX_NOTES)
) (
    input  logic [1:0]         sel_i,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [ENTRY_W-1:0] entry_o
);
    // table lookup; anything not listed is the all-zero end marker
    always_comb begin
        entry_o = '0;
        case (sel_i)
            MEL_START: case (32'(idx_i))
                0: entry_o = mk_entry(NOTE_C4, 6'd15);
                1: entry_o = mk_entry(NOTE_E4, 6'd15);
                2: entry_o = mk_entry(NOTE_G4, 6'd15);
                3: entry_o = mk_entry(NOTE_C5, 6'd15);
                default: entry_o = '0;
            endcase
            MEL_GAMEOVER: case (32'(idx_i))
                0: entry_o = mk_entry(NOTE_G4, 6'd30);
                1: entry_o = mk_entry(NOTE_DS4, 6'd30);
                2: entry_o = mk_entry(NOTE_C4, 6'd30);
                default: entry_o = '0;
            endcase
            MEL_LEVELUP: case (32'(idx_i))
                0: entry_o = mk_entry(NOTE_C5, 6'd8);
                1: entry_o = mk_entry(NOTE_E5, 6'd8);
                2: entry_o = mk_entry(NOTE_G5, 6'd8);
                3: entry_o = mk_entry(10'd0, 6'd5);
                4: entry_o = mk_entry(NOTE_B5, 6'd20);
                default: entry_o = '0;
            endcase
            default: entry_o = '0;
        endcase
    end
endmodule

// File: rtl/melody_player.sv
// melody_player: steps through a ROM jingle, holding each frequency for a millisecond-accurate duration
module melody_player
    import melody_pkg::*;
#(
    parameter int DUR_UNIT_MS = 10,
    parameter int GAP_MS      = 20,
    parameter int MAX_NOTES   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ticks_per_milli,
    input  logic        play,
    input  logic [1:0]  melody_sel,
    input  logic        stop,
    output logic [9:0]  freq,
    output logic        busy,
    output logic        done
);
    localparam int IDX_W = $clog2(MAX_NOTES);

    state_t             state_q, state_d, adv_state;
    logic [1:0]         sel_q, sel_d;
    logic [15:0]        tpm_q, tpm_d, ms_cnt_q, ms_cnt_d, rem_q, rem_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FREQ_W-1:0]  freq_q, freq_d, e_freq;
    logic [DUR_W-1:0]   e_dur;
    logic [ENTRY_W-1:0] entry;
    logic               busy_q, done_q, in_phase, ms_tick, phase_end;

    melody_rom #(.MAX_NOTES(MAX_NOTES)) u_rom (.sel_i(sel_q), .idx_i(idx_q), .entry_o(entry));

    assign e_freq    = entry[ENTRY_W-1 -: FREQ_W];
    assign e_dur     = entry[DUR_W-1:0];
    assign in_phase  = state_q == NOTE || state_q == GAP;
    assign ms_tick   = ms_cnt_q == tpm_q - 16'd1;
    assign phase_end = ms_tick && rem_q == 16'd1;
    assign adv_state = idx_q == IDX_W'(MAX_NOTES - 1) ? DONE : FETCH;

    // sequencing: rem_q counts milliseconds left in the current NOTE/GAP phase
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        tpm_d    = tpm_q;
        idx_d    = idx_q;
        freq_d   = freq_q;
        ms_cnt_d = in_phase ? (ms_tick ? '0 : ms_cnt_q + 16'd1) : ms_cnt_q;
        rem_d    = in_phase && ms_tick ? rem_q - 16'd1 : rem_q;
        case (state_q)
            IDLE: if (play && !stop) begin
                state_d = FETCH;
                sel_d   = melody_sel;
                tpm_d   = ticks_per_milli == '0 ? 16'd1 : ticks_per_milli;
                idx_d   = '0;
            end
            FETCH: if (e_freq == '0 && e_dur == '0) begin
                state_d = DONE;
            end else if (e_dur == '0) begin
                state_d = adv_state;
                idx_d   = idx_q + IDX_W'(1);
            end else begin
                state_d  = NOTE;
                freq_d   = e_freq;
                rem_d    = 16'(e_dur) * 16'(DUR_UNIT_MS);
                ms_cnt_d = '0;
            end
            NOTE: if (phase_end) begin
                freq_d   = '0;
                ms_cnt_d = '0;
                if (freq_q != '0 && GAP_MS > 0) begin
                    state_d = GAP;
                    rem_d   = 16'(GAP_MS);
                end else begin
                    state_d = adv_state;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            GAP: if (phase_end) begin
                state_d = adv_state;
                idx_d   = idx_q + IDX_W'(1);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            freq_d  = '0;
        end
    end

    // state and registered outputs; done fires as DONE hands back to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            tpm_q    <= '0;
            idx_q    <= '0;
            ms_cnt_q <= '0;
            rem_q    <= '0;
            freq_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            tpm_q    <= tpm_d;
            idx_q    <= idx_d;
            ms_cnt_q <= ms_cnt_d;
            rem_q    <= rem_d;
            freq_q   <= freq_d;
            busy_q   <= state_d != IDLE;
            done_q   <= state_q == DONE && !stop;
        end
    end

    assign freq = freq_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_melody_player.sv
// tb_melody_player: timeline reference model with per-cycle compare, directed pins and random traffic
module tb_melody_player;
    logic        clk = 1'b0;
    logic        rst, play, stop;
    logic [15:0] tpm;
    logic [1:0]  sel;
    logic [9:0]  freq;
    logic        busy, done;

    int n_vec = 0;
    int n_err = 0;

    melody_player dut (
        .clk(clk), .rst(rst), .ticks_per_milli(tpm), .play(play),
        .melody_sel(sel), .stop(stop), .freq(freq), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] f;
        logic       b;
        logic       d;
    } ev_t;

    ev_t cur = '0;
    ev_t tl[$];
    bit  started = 1'b0;

    int mel_f [4][5] = '{'{262, 330, 392, 523, 0}, '{392, 311, 262, 0, 0},
                         '{523, 659, 784, 0, 988}, '{0, 0, 0, 0, 0}};
    int mel_d [4][5] = '{'{15, 15, 15, 15, 0}, '{30, 30, 30, 0, 0},
                         '{8, 8, 8, 5, 20}, '{0, 0, 0, 0, 0}};

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // expand a whole melody into the per-cycle outputs it must produce
    task automatic build(input int s, input int t_in);
        int t = t_in == 0 ? 1 : t_in;
        for (int i = 0; i < 16; i++) begin
            int f = i < 5 ? mel_f[s][i] : 0;
            int d = i < 5 ? mel_d[s][i] : 0;
            tl.push_back('{10'd0, 1'b1, 1'b0});
            if (f == 0 && d == 0) begin
                tl.push_back('{10'd0, 1'b1, 1'b0});
                tl.push_back('{10'd0, 1'b0, 1'b1});
                return;
            end
            if (d != 0) begin
                repeat (d * 10 * t) tl.push_back('{10'(f), 1'b1, 1'b0});
                if (f != 0) repeat (20 * t) tl.push_back('{10'd0, 1'b1, 1'b0});
            end
        end
        tl.push_back('{10'd0, 1'b1, 1'b0});
        tl.push_back('{10'd0, 1'b0, 1'b1});
    endtask

    always @(posedge clk) begin
        if (rst) begin
            tl.delete();
            cur = '0;
            started = 1'b1;
        end else if (stop && cur.b) begin
            tl.delete();
            cur = '0;
        end else begin
            if (!cur.b && play && !stop) build(int'(sel), int'(tpm));
            cur = tl.size() > 0 ? tl.pop_front() : '0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_freq", int'(freq), int'(cur.f));
            chk("model_busy", int'(busy), int'(cur.b));
            chk("model_done", int'(done), int'(cur.d));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_freq(input int v, input string nm);
        int n = 0;
        while (int'(freq) != v && n < 20000) begin
            n++;
            tick();
        end
        chk(nm, int'(freq), v);
    endtask

    task automatic run_len(input int v, output int n);
        n = 0;
        while (int'(freq) == v && n < 20000) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 20000) begin
            n++;
            tick();
        end
        chk(nm, int'(done), 1);
    endtask

    initial begin
        int n;
        bit seen;
        rst = 1'b1; play = 1'b0; stop = 1'b0; sel = 2'd0; tpm = 16'd2;
        repeat (3) tick();
        chk("reset_freq", int'(freq), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;
        tick();

        sel = 2'd0; play = 1'b1;
        tick();
        chk("start_busy", int'(busy), 1);
        chk("start_fetch_silent", int'(freq), 0);
        play = 1'b0;
        tick();
        chk("start_first", int'(freq), 262);
        play = 1'b1; tpm = 16'd7;
        repeat (299) tick();
        chk("start_hold_end", int'(freq), 262);
        play = 1'b0; tpm = 16'd2;
        tick();
        chk("gap_start", int'(freq), 0);
        repeat (40) tick();
        chk("gap_plus_fetch", int'(freq), 0);
        tick();
        chk("second_note", int'(freq), 330);
        wait_done("start_done");
        chk("start_busy_low", int'(busy), 0);
        tick();
        chk("done_one_cycle", int'(done), 0);

        sel = 2'd3; play = 1'b1;
        tick();
        chk("silent_busy1", int'(busy), 1);
        play = 1'b0;
        tick();
        chk("silent_busy2", int'(busy), 1);
        chk("silent_freq", int'(freq), 0);
        tick();
        chk("silent_done", int'(done), 1);
        chk("silent_busy_low", int'(busy), 0);
        tick();
        chk("silent_done_clear", int'(done), 0);

        sel = 2'd2; tpm = 16'd2; play = 1'b1;
        tick();
        play = 1'b0;
        wait_freq(784, "lvl_g5");
        run_len(784, n);
        chk("lvl_g5_len", n, 160);
        run_len(0, n);
        chk("lvl_gap_rest_len", n, 142);
        chk("lvl_b5", int'(freq), 988);
        run_len(988, n);
        chk("lvl_b5_len", n, 400);
        wait_done("lvl_done");

        sel = 2'd1; tpm = 16'd1; play = 1'b1;
        tick();
        play = 1'b0;
        wait_freq(311, "go_second");
        repeat (10) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_freq", int'(freq), 0);
        chk("stop_busy", int'(busy), 0);
        seen = 1'b0;
        repeat (5) begin
            tick();
            seen |= done;
        end
        chk("stop_no_done", int'(seen), 0);
        play = 1'b1;
        tick();
        play = 1'b0;
        tick();
        chk("restart_first", int'(freq), 392);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        sel = 2'd0; tpm = 16'd0; play = 1'b1;
        tick();
        play = 1'b0;
        tick();
        chk("tpm0_first", int'(freq), 262);
        run_len(262, n);
        chk("tpm0_len", n, 150);
        run_len(0, n);
        chk("tpm0_gap_len", n, 21);
        chk("tpm0_second", int'(freq), 330);
        rst = 1'b1;
        tick();
        chk("rst_mid_freq", int'(freq), 0);
        chk("rst_mid_busy", int'(busy), 0);
        rst = 1'b0;
        tick();

        repeat (30000) begin
            rst  = $urandom_range(5999) == 0;
            play = $urandom_range(9) == 0;
            stop = $urandom_range(2499) == 0;
            sel  = 2'($urandom_range(3));
            tpm  = 16'($urandom_range(3));
            tick();
        end
        rst = 1'b0; play = 1'b0; stop = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/melody_player.md
Name: melody_player

Overview:
- Upstream sequencer for the square-wave tone stage: it plays fixed jingles (game start, game over, level up) by presenting one 10-bit frequency at a time.
- The tone stage consumes `freq` directly; `freq` = 0 means silence.
- Timing is derived from the shared `ticks_per_milli` input, so durations are in real milliseconds at any system clock.
- Melody data lives in a small combinational ROM sub-module.

Parameters:
- DUR_UNIT_MS, 10, milliseconds per ROM duration unit.
- GAP_MS, 20, silent gap in ms inserted after every sounded note (0 = no gap).
- MAX_NOTES, 16, entries per melody slot (index width = clog2(MAX_NOTES)).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ticks_per_milli  in  16  clock ticks per millisecond; sampled on play accept
- play  in  1  start request (level-sampled; accepted only in IDLE)
- melody_sel  in  2  melody to play; sampled with play
- stop  in  1  abort current melody
- freq  out  10  frequency in Hz to the tone stage; 0 = silent
- busy  out  1  high while a melody is in progress
- done  out  1  one-cycle pulse on natural completion

Behaviour:
- Reset: state=IDLE, freq=0, busy=0, done=0, all counters=0. Reset mid-melody silences `freq` on the next edge.
- ROM entry is 16 bits: {freq[9:0], dur[5:0]}.
  - freq=0, dur=0: end marker.
  - freq=0, dur>0: rest.
  - freq>0, dur=0: skipped entry (no sound, no gap).
- Millisecond prescaler: `ms_cnt` counts 0..tpm-1, and `ms_tick` fires when ms_cnt == tpm-1.
  - tpm is the latched `ticks_per_milli`; a latched value of 0 is treated as 1.
  - The prescaler and the unit counters restart at entry to every NOTE and GAP phase, so durations are exact.
- IDLE:
  - freq=0, busy=0.
  - If play=1 and stop=0: latch melody_sel and tpm, idx=0, busy=1 next cycle, go to FETCH.
- FETCH (1 cycle): read rom[sel][idx].
  - End marker -> DONE.
  - dur=0 with freq>0 -> advance idx, stay in FETCH.
  - Otherwise: freq<=entry.freq, remaining<=dur*DUR_UNIT_MS ms, go to NOTE.
  - Net effect: first note appears on `freq` 2 cycles after play is sampled.
- NOTE:
  - freq is held for exactly dur*DUR_UNIT_MS*tpm cycles.
  - Then freq<=0.
  - If entry.freq>0 and GAP_MS>0 -> GAP; otherwise (rest, or GAP_MS=0) -> advance.
- GAP: freq=0 for GAP_MS*tpm cycles, then advance.
- Advance:
  - If idx == MAX_NOTES-1 -> DONE (implicit end).
  - Otherwise idx++ and go to FETCH.
- DONE (1 cycle): done=1, busy=0, freq=0, then IDLE.
- Handshakes and simultaneous events:
  - play while busy is ignored; no queueing.
  - play and stop in the same cycle in IDLE: no start.
  - stop in any non-IDLE state: next edge freq=0, busy=0, state=IDLE, no done pulse.
  - stop has priority over a phase ending in the same cycle.
- Arithmetic: the ms counter for a phase is 16 bits (max 63*10 = 630 ms); the tick prescaler is 16 bits; no overflow is possible.
- Outputs are registered; `freq` never glitches to a non-ROM value.

Decomposition:
- Shared package (`melody_pkg`) holds:
  - Note-frequency constants: NOTE_C4=262, NOTE_E4=330, NOTE_G4=392, NOTE_DS4=311, NOTE_C5=523, NOTE_E5=659, NOTE_G5=784, NOTE_B5=988.
  - Melody IDs: MEL_START=0, MEL_GAMEOVER=1, MEL_LEVELUP=2, MEL_SILENT=3.
  - ROM entry field widths and the state enum {IDLE, FETCH, NOTE, GAP, DONE}.
- One sub-module, `melody_rom`: combinational, (sel, idx) -> 16-bit entry. Contents:
  - START: C4, E4, G4, C5, each dur 15.
  - GAMEOVER: G4, DS4, C4, each dur 30.
  - LEVELUP: C5, E5, G5, rest dur 5, B5 dur 20; other notes dur 8.
  - SILENT: end marker at idx 0.

Test Plan:
- tpm=2, play with sel=START:
  - freq=262 appears 2 cycles after play and holds 300 cycles.
  - Then 0 for 40 cycles, then 330.
  - After C5 and its gap, done pulses once and busy drops.
- tpm=2, sel=SILENT: busy is high 2 cycles, done pulses, freq stays 0 throughout.
- sel=LEVELUP: the rest entry gives freq=0 for exactly 5*10*2 = 100 cycles with no extra gap; then 988 for 400 cycles.
- Start GAMEOVER, assert stop during the second note: next cycle freq=0, busy=0, no done pulse; a new play afterwards restarts at idx 0 (freq=392).
- play re-asserted while busy (mid START): ignored, sequence unchanged. ticks_per_milli changed mid-melody: durations unchanged (latched value used).
- ticks_per_milli=0: behaves as 1, so the first START note lasts 150 cycles. rst asserted mid-note: freq=0, busy=0 on the next edge.
